// File: rtl/shift_deserializer.sv
// Start/stop framed serial-to-parallel receiver with a one-word output buffer.
// Sticky flags record stop-bit errors and words dropped while the buffer was full.
module shift_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             SerialIn,
    input  logic             Enable,
    input  logic             LSBFirst,
    input  logic             Ready,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             Valid,
    output logic             Busy,
    output logic             FrameErr,
    output logic             Overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               lsb_q;

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            lsb_q    <= 1'b0;
            Data_OUT <= '0;
            Valid    <= 1'b0;
            Busy     <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            // Consumer handshake; a completing good frame below overrides this.
            if (Valid && Ready) begin
                Valid <= 1'b0;
            end

            if (Enable) begin
                case (state)
                    IDLE: begin
                        if (!SerialIn) begin
                            state   <= DATA;
                            lsb_q   <= LSBFirst;
                            bit_cnt <= '0;
                            Busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (lsb_q) begin
                            shreg <= {SerialIn, shreg[WIDTH-1:1]};
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], SerialIn};
                        end
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (SerialIn) begin
                            // Load only if the buffer is empty or drains this cycle.
                            if (!Valid || Ready) begin
                                Data_OUT <= shreg;
                                Valid    <= 1'b1;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            FrameErr <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (WIDTH=4).
module tb_shift_deserializer;

    localparam int unsigned WIDTH = 4;

    logic             clock    = 1'b0;
    logic             reset_b  = 1'b0;
    logic             SerialIn = 1'b1;
    logic             Enable   = 1'b0;
    logic             LSBFirst = 1'b0;
    logic             Ready    = 1'b0;
    logic [WIDTH-1:0] Data_OUT;
    logic             Valid;
    logic             Busy;
    logic             FrameErr;
    logic             Overrun;

    int checks = 0;
    int errors = 0;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset_b  (reset_b),
        .SerialIn (SerialIn),
        .Enable   (Enable),
        .LSBFirst (LSBFirst),
        .Ready    (Ready),
        .Data_OUT (Data_OUT),
        .Valid    (Valid),
        .Busy     (Busy),
        .FrameErr (FrameErr),
        .Overrun  (Overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset with every other input driven active to show reset wins.
    task automatic do_reset();
        reset_b  = 1'b0;
        Enable   = 1'b1;
        SerialIn = 1'b0;
        Ready    = 1'b1;
        tick();
        tick();
        reset_b  = 1'b1;
        Enable   = 1'b0;
        SerialIn = 1'b1;
        Ready    = 1'b0;
    endtask

    // Sends start, d[3]..d[0], stop; gap idle cycles between bits with SerialIn flipped.
    task automatic frame(input logic [3:0] d, input logic stopb, input logic lsb,
                         input logic toggle, input int gap, input logic rdy_stop);
        logic [5:0] bits;
        bits = {1'b0, d, stopb};
        for (int i = 5; i >= 0; i--) begin
            SerialIn = bits[i];
            Enable   = 1'b1;
            LSBFirst = (i == 5) ? lsb : (toggle ? ~lsb : lsb);
            if (i == 0) Ready = rdy_stop;
            tick();
            if (i == 5) check("busy_after_start", 16'(Busy), 16'd1);
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    Enable   = 1'b0;
                    SerialIn = ~bits[i];
                    LSBFirst = ~LSBFirst;
                    tick();
                end
            end
        end
        Enable   = 1'b0;
        SerialIn = 1'b1;
        Ready    = 1'b0;
    endtask

    task automatic consume(input logic [3:0] exp_data);
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        check("consume_valid", 16'(Valid), 16'd0);
        check("consume_data", 16'(Data_OUT), 16'(exp_data));
    endtask

    initial begin
        do_reset();
        check("rst_data", 16'(Data_OUT), 16'h0);
        check("rst_valid", 16'(Valid), 16'd0);
        check("rst_busy", 16'(Busy), 16'd0);
        check("rst_ferr", 16'(FrameErr), 16'd0);
        check("rst_ovr", 16'(Overrun), 16'd0);

        // Idle line with Enable and Ready high must not start or flag anything.
        Enable = 1'b1; SerialIn = 1'b1; Ready = 1'b1;
        tick(); tick();
        Enable = 1'b0; Ready = 1'b0;
        check("idle_busy", 16'(Busy), 16'd0);
        check("idle_valid", 16'(Valid), 16'd0);

        // MSB-first, continuous enable.
        frame(4'b1011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("msb_data", 16'(Data_OUT), 16'hB);
        check("msb_valid", 16'(Valid), 16'd1);
        check("msb_busy", 16'(Busy), 16'd0);
        consume(4'hB);

        // LSB-first, LSBFirst flipped during data bits.
        frame(4'b1011, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        check("lsb_data", 16'(Data_OUT), 16'hD);
        check("lsb_valid", 16'(Valid), 16'd1);
        consume(4'hD);

        // Enable every third cycle, line wiggling in between.
        frame(4'b1011, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        check("strobe_data", 16'(Data_OUT), 16'hB);
        check("strobe_valid", 16'(Valid), 16'd1);
        consume(4'hB);

        // Bad stop bit, then a good frame.
        frame(4'b0110, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("ferr_flag", 16'(FrameErr), 16'd1);
        check("ferr_valid", 16'(Valid), 16'd0);
        check("ferr_data", 16'(Data_OUT), 16'hB);
        check("ferr_ovr", 16'(Overrun), 16'd0);
        frame(4'b0110, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("after_ferr_data", 16'(Data_OUT), 16'h6);
        check("after_ferr_valid", 16'(Valid), 16'd1);
        check("ferr_sticky", 16'(FrameErr), 16'd1);
        consume(4'h6);

        // Overrun: second word dropped while first unconsumed.
        do_reset();
        frame(4'b1001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        frame(4'b0011, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("ovr_valid", 16'(Valid), 16'd1);
        check("ovr_data", 16'(Data_OUT), 16'h9);
        check("ovr_flag", 16'(Overrun), 16'd1);

        // Ready on the completion cycle lets the new word replace the old.
        do_reset();
        frame(4'b1001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        frame(4'b0011, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        check("swap_valid", 16'(Valid), 16'd1);
        check("swap_data", 16'(Data_OUT), 16'h3);
        check("swap_ovr", 16'(Overrun), 16'd0);
        consume(4'h3);

        // Reset after the second data bit aborts the frame.
        Enable = 1'b1;
        SerialIn = 1'b0; tick();
        SerialIn = 1'b1; tick();
        SerialIn = 1'b1; tick();
        check("mid_busy_pre", 16'(Busy), 16'd1);
        reset_b = 1'b0; SerialIn = 1'b0; Ready = 1'b1;
        tick();
        reset_b = 1'b1; Enable = 1'b0; SerialIn = 1'b1; Ready = 1'b0;
        check("mid_rst_busy", 16'(Busy), 16'd0);
        check("mid_rst_data", 16'(Data_OUT), 16'h0);
        check("mid_rst_valid", 16'(Valid), 16'd0);
        frame(4'b1100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("post_rst_data", 16'(Data_OUT), 16'hC);
        check("post_rst_valid", 16'(Valid), 16'd1);
        check("post_rst_ferr", 16'(FrameErr), 16'd0);
        check("post_rst_ovr", 16'(Overrun), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame; legal range 2..16.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset_b  input  1  reset, synchronous and active-low; sampled on posedge clock.
REQ-004 SerialIn  input  1  serial line; idle level 1.
REQ-005 Enable  input  1  bit strobe; SerialIn is sampled only on cycles with Enable=1.
REQ-006 LSBFirst  input  1  bit order: 1 = first data bit is Data_OUT[0]; 0 = first data bit is Data_OUT[WIDTH-1].
REQ-007 Ready  input  1  consumer accepts Data_OUT on a cycle with Valid=1 and Ready=1.
REQ-008 Data_OUT  output  WIDTH  last good received word.
REQ-009 Valid  output  1  Data_OUT holds an unconsumed word.
REQ-010 Busy  output  1  frame in progress (state != IDLE).
REQ-011 FrameErr  output  1  sticky; a stop bit sampled as 0.
REQ-012 Overrun  output  1  sticky; a good frame completed while a previous word was unconsumed.

Function
REQ-013 Frame format: start bit (0), then WIDTH data bits, then stop bit (1); one bit per Enable=1 cycle.
REQ-014 Cycles with Enable=0 leave state, bit counter and shift register unchanged.
REQ-015 FSM states: IDLE, DATA, STOP; Busy=1 in DATA and STOP.
REQ-016 IDLE -> DATA when Enable=1 and SerialIn=0; LSBFirst is captured on this cycle and held for the frame.
REQ-017 IDLE with Enable=1 and SerialIn=1: remain IDLE.
REQ-018 DATA: each Enable=1 cycle shifts SerialIn into the shift register and increments a bit counter starting at 0.
REQ-019 MSB-first (captured LSBFirst=0): shift left, SerialIn enters bit 0.
REQ-020 LSB-first (captured LSBFirst=1): shift right, SerialIn enters bit WIDTH-1.
REQ-021 DATA -> STOP on the Enable cycle that samples data bit WIDTH-1; the counter wraps to 0.
REQ-022 STOP with Enable=1 and SerialIn=1: good frame; -> IDLE.
REQ-023 STOP with Enable=1 and SerialIn=0: FrameErr <= 1; word discarded; Data_OUT, Valid and Overrun unchanged; -> IDLE.
REQ-024 Good frame with Valid=0: Data_OUT <= shift register and Valid <= 1, visible the cycle after the stop-bit Enable cycle (latency 1).
REQ-025 Good frame with Valid=1 and Ready=0: Overrun <= 1; new word dropped; Data_OUT retains the old word; Valid stays 1.
REQ-026 Good frame on the same cycle as Valid=1 and Ready=1: the new word loads; Valid stays 1; Overrun unchanged.
REQ-027 Valid=1 and Ready=1 with no good frame completing: Valid <= 0 next cycle; Data_OUT holds its value.
REQ-028 Ready is ignored while Valid=0.
REQ-029 A start bit may be accepted on the first Enable cycle after returning to IDLE, independent of Valid.
REQ-030 FrameErr and Overrun clear only on reset.

Reset
REQ-031 reset_b=0 at a posedge sets: state IDLE, bit counter 0, shift register 0, Data_OUT 0, Valid 0, Busy 0, FrameErr 0, Overrun 0.
REQ-032 Reset overrides all other inputs, including Enable and Ready.
REQ-033 Reset mid-frame (DATA or STOP) aborts the frame with no Valid, FrameErr or Overrun effect after release.
REQ-034 On the first cycle after reset_b returns to 1, the block is in IDLE and can accept a start bit.

Verification
REQ-035 WIDTH=4, LSBFirst=0, Enable every cycle, SerialIn 0,1,0,1,1,1 -> Data_OUT=4'b1011, Valid=1 one cycle after the stop bit, Busy=0.
REQ-036 Same bit stream with LSBFirst=1 -> Data_OUT=4'b1101; LSBFirst toggled mid-frame has no effect on the result.
REQ-037 Enable strobed every 3rd cycle with the stream from REQ-035 -> identical result; SerialIn changes on Enable=0 cycles are ignored.
REQ-038 Stop bit sampled 0 -> FrameErr=1, Valid stays 0, Data_OUT unchanged; a following good frame is still received.
REQ-039 Two good frames with Ready=0 -> Valid=1, Data_OUT=first word, Overrun=1; repeat with Ready=1 on the completion cycle -> Data_OUT=second word, Overrun=0.
REQ-040 reset_b=0 after the 2nd data bit -> all outputs 0; a full new frame after release is received correctly.
